// File: rtl/jtcps1_gfx_sched_pkg.sv
// rtl/jtcps1_gfx_sched_pkg.sv - shared types and helpers for the graphics ROM fetch scheduler
package jtcps1_gfx_sched_pkg;

  typedef enum logic [2:0] {
    LYR_OBJ   = 3'd0,
    LYR_SCR1  = 3'd1,
    LYR_SCR2  = 3'd2,
    LYR_SCR3  = 3'd3,
    LYR_STARS = 3'd4
  } layer_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAP   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_ISSUE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // All pens at 15 so an unmapped tile reads back fully transparent
  localparam logic [31:0] BLANK_DEFAULT = 32'hFFFF_FFFF;

  // Round-robin pointer advance: the layer after the one just granted, STARS wraps to OBJ
  function automatic logic [2:0] next_ptr(input logic [2:0] g);
    return (g >= LYR_STARS) ? LYR_OBJ : g + 3'd1;
  endfunction

  function automatic logic [4:0] layer_onehot(input logic [2:0] g);
    return 5'd1 << g;
  endfunction

endpackage

// File: rtl/jtcps1_gfx_rr.sv
// rtl/jtcps1_gfx_rr.sv - combinational 5-way round-robin picker
module jtcps1_gfx_rr (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_idx,
  output logic       any
);

  logic [2:0] ptr_ok;
  int         idx;

  // Pointer codes beyond STARS are unreachable; fold them onto OBJ so the search stays in range
  assign ptr_ok = (ptr > 3'd4) ? 3'd0 : ptr;
  assign any    = |req;

  // Scan from farthest to nearest so the requester closest at/after the pointer wins
  always_comb begin
    gnt_idx = 3'd0;
    idx     = 0;
    for (int i = 4; i >= 0; i--) begin
      idx = int'(ptr_ok) + i;
      if (idx >= 5) idx = idx - 5;
      if (req[3'(idx)]) gnt_idx = 3'(idx);
    end
  end

endmodule

// File: rtl/jtcps1_gfx_sched.sv
// rtl/jtcps1_gfx_sched.sv - arbitrates layer fetches, maps tile banks and runs the ROM handshake
module jtcps1_gfx_sched
  import jtcps1_gfx_sched_pkg::*;
#(
  parameter int              AW      = 20,
  parameter int              DW      = 32,
  parameter int              MAP_LAT = 2,
  parameter logic [DW-1:0]   BLANK   = DW'(BLANK_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        req,
  input  logic [5*AW-1:0]   addr,
  output logic [4:0]        ok,
  output logic [DW-1:0]     dout,
  output logic              map_en,
  output logic [2:0]        map_layer,
  output logic [9:0]        map_cin,
  input  logic [3:0]        map_offset,
  input  logic [3:0]        map_mask,
  input  logic              map_unmapped,
  output logic [AW-1:0]     rom_addr,
  output logic              rom_cs,
  input  logic              rom_ok,
  input  logic [DW-1:0]     rom_data
);

  // WAIT lasts MAP_LAT-1 cycles; the counter is loaded with one less than that
  localparam logic [1:0] WAIT_LOAD = (MAP_LAT > 2) ? 2'(MAP_LAT - 2) : 2'd0;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [1:0]      wait_q, wait_d;
  logic [4:0]      ok_q, ok_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            map_en_q, map_en_d;
  logic [2:0]      map_layer_q, map_layer_d;
  logic [9:0]      map_cin_q, map_cin_d;
  logic            rom_cs_q, rom_cs_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;

  logic [2:0]      gnt_idx;
  logic            gnt_any;
  logic [AW-1:0]   addr_sel;

  jtcps1_gfx_rr u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Pick the winning layer's address lane
  always_comb begin
    addr_sel = addr[AW-1:0];
    for (int i = 0; i < 5; i++) begin
      if (gnt_idx == 3'(i)) addr_sel = addr[i*AW +: AW];
    end
  end

  // Next-state and registered-output computation for the fetch sequence
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    wait_d      = wait_q;
    ok_d        = 5'd0;
    dout_d      = dout_q;
    map_en_d    = 1'b0;
    map_layer_d = map_layer_q;
    map_cin_d   = map_cin_q;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          grant_d     = gnt_idx;
          addr_d      = addr_sel;
          ptr_d       = next_ptr(gnt_idx);
          map_layer_d = gnt_idx;
          map_cin_d   = addr_sel[AW-1:AW-10];
          map_en_d    = 1'b1;
          state_d     = ST_MAP;
        end
      end
      ST_MAP: begin
        wait_d  = WAIT_LOAD;
        state_d = (MAP_LAT <= 1) ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == 2'd0) state_d = ST_CHECK;
        else                wait_d  = wait_q - 2'd1;
      end
      ST_CHECK: begin
        if (map_unmapped) begin
          dout_d  = BLANK;
          ok_d    = layer_onehot(grant_q);
          state_d = ST_DONE;
        end else begin
          rom_addr_d = {(addr_q[AW-1:AW-4] & map_mask) | map_offset, addr_q[AW-5:0]};
          rom_cs_d   = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rom_ok) begin
          dout_d   = rom_data;
          rom_cs_d = 1'b0;
          ok_d     = layer_onehot(grant_q);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 3'd0;
      addr_q      <= '0;
      ptr_q       <= 3'd0;
      wait_q      <= 2'd0;
      ok_q        <= 5'd0;
      dout_q      <= '0;
      map_en_q    <= 1'b0;
      map_layer_q <= 3'd0;
      map_cin_q   <= 10'd0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      ptr_q       <= ptr_d;
      wait_q      <= wait_d;
      ok_q        <= ok_d;
      dout_q      <= dout_d;
      map_en_q    <= map_en_d;
      map_layer_q <= map_layer_d;
      map_cin_q   <= map_cin_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  assign ok        = ok_q;
  assign dout      = dout_q;
  assign map_en    = map_en_q;
  assign map_layer = map_layer_q;
  assign map_cin   = map_cin_q;
  assign rom_cs    = rom_cs_q;
  assign rom_addr  = rom_addr_q;

endmodule
